// File: rtl/mem_pkg.sv
// Shared definitions for the byte-wide memory controller clients.
// Holds the access size encodings, the client FSM state type, the flush
// recovery length, and a helper that maps a size code to the index of the
// last byte of the access.
package mem_pkg;

    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    localparam int FLUSH_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FLUSH = 2'd3
    } mem_state_t;

    // Index of the final byte of an access (N-1); size 3 behaves as a word.
    function automatic logic [1:0] size_last(input logic [1:0] size);
        case (size)
            MEM_B:   return 2'd0;
            MEM_H:   return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extension: takes four little-endian captured bytes and returns
// an XLEN-wide value zero- or sign-extended from 8 or 16 bits, or the raw
// 32-bit word. Purely combinational; shared with the icache fetch path.
// Ports:
//   bytes_in  [31:0]      captured bytes, byte i in bits [8i+7:8i]
//   size      [1:0]       MEM_B / MEM_H / MEM_W (3 treated as word)
//   sign_ext              1 = sign-extend, 0 = zero-extend
//   data_out  [XLEN-1:0]  extended result (XLEN must be at least 32)
module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     bytes_in,
    input  logic [1:0]      size,
    input  logic            sign_ext,
    output logic [XLEN-1:0] data_out
);

    logic fill;

    always_comb begin
        fill     = 1'b0;
        data_out = '0;
        case (size)
            MEM_B: begin
                fill     = sign_ext & bytes_in[7];
                data_out = {{(XLEN-8){fill}}, bytes_in[7:0]};
            end
            MEM_H: begin
                fill     = sign_ext & bytes_in[15];
                data_out = {{(XLEN-16){fill}}, bytes_in[15:0]};
            end
            default: begin
                data_out = XLEN'(bytes_in);
            end
        endcase
    end

endmodule

// File: rtl/dcache_mem_client.sv
// dcache-side client of the byte-wide memory controller. Accepts one load or
// store of 1, 2 or 4 bytes at any alignment and runs it as a sequence of
// single-byte accesses on the controller's request/grant interface. Loads are
// reassembled little-endian and extended; stores are split into byte writes.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req_valid / req_ready       request handshake (ready only in IDLE)
//   req_write, req_size,
//   req_signed, req_addr,
//   req_wdata                   request fields, latched on accept
//   flush                       cancels an in-flight load
//   resp_valid, resp_rdata      one-cycle completion pulse and load data
//   mc_rw_en, mc_write_mode,
//   mc_addr, mc_data            request side of the controller dcache port
//   mc_out_en, mc_din           grant (rw_en delayed one cycle) and read byte
module dcache_mem_client
    import mem_pkg::*;
#(
    parameter int ADDR_W = 18,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              flush,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              mc_rw_en,
    output logic              mc_write_mode,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [7:0]        mc_data,
    input  logic              mc_out_en,
    input  logic [7:0]        mc_din
);

    mem_state_t        state, state_nxt;
    logic [ADDR_W-1:0] base_addr;
    logic [XLEN-1:0]   wdata_q;
    logic              write_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        idx;
    logic [1:0]        rcv;
    logic              rd_pend;
    logic [1:0]        flush_cnt;
    logic [31:0]       rbuf;
    logic [31:0]       cap_bytes;
    logic [XLEN-1:0]   ext_data;

    logic accept;
    logic is_last;
    logic capture;
    logic issue_fire;
    logic store_done;
    logic load_done;
    logic enter_flush;

    assign accept  = req_valid && req_ready;
    assign is_last = (idx == size_last(size_q));
    // Read bytes are only meaningful while the load is still live; anything
    // arriving during FLUSH belongs to a cancelled access.
    assign capture = rd_pend && ((state == ISSUE) || (state == WAIT));

    // Captured bytes with the byte arriving this cycle merged in, so the
    // final byte can be extended and registered in the same cycle.
    always_comb begin
        cap_bytes = rbuf;
        if (capture) begin
            cap_bytes[{rcv, 3'b000} +: 8] = mc_din;
        end
    end

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .bytes_in (cap_bytes),
        .size     (size_q),
        .sign_ext (signed_q),
        .data_out (ext_data)
    );

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        mc_rw_en      = 1'b0;
        mc_write_mode = 1'b0;
        mc_addr       = '0;
        mc_data       = '0;
        issue_fire    = 1'b0;
        store_done    = 1'b0;
        load_done     = 1'b0;
        enter_flush   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mc_write_mode = write_q;
                mc_addr       = base_addr + ADDR_W'(idx);
                mc_data       = wdata_q[{idx, 3'b000} +: 8];
                // Request drops in the final grant cycle so the controller
                // never sees a trailing request (no duplicate write).
                mc_rw_en      = !(mc_out_en && is_last) && !(flush && !write_q);
                if (flush && !write_q) begin
                    state_nxt   = FLUSH;
                    enter_flush = 1'b1;
                end else if (mc_out_en) begin
                    issue_fire = 1'b1;
                    if (is_last) begin
                        if (write_q) begin
                            state_nxt  = IDLE;
                            store_done = 1'b1;
                        end else begin
                            state_nxt = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                // Only loads reach WAIT; flush beats the final capture.
                if (flush) begin
                    state_nxt   = FLUSH;
                    enter_flush = 1'b1;
                end else if (rd_pend) begin
                    state_nxt = IDLE;
                    load_done = 1'b1;
                end
            end
            FLUSH: begin
                if (flush_cnt == 2'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            idx        <= 2'd0;
            rcv        <= 2'd0;
            rd_pend    <= 1'b0;
            flush_cnt  <= 2'd0;
            write_q    <= 1'b0;
            size_q     <= MEM_B;
            signed_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            resp_valid <= store_done || load_done;
            rd_pend    <= mc_out_en && !write_q && (state == ISSUE);
            if (accept) begin
                idx      <= 2'd0;
                rcv      <= 2'd0;
                write_q  <= req_write;
                size_q   <= req_size;
                signed_q <= req_signed;
            end else begin
                if (issue_fire) begin
                    idx <= idx + 2'd1;
                end
                if (capture) begin
                    rcv <= rcv + 2'd1;
                end
            end
            if (store_done) begin
                resp_rdata <= '0;
            end else if (load_done) begin
                resp_rdata <= ext_data;
            end
            if (enter_flush) begin
                flush_cnt <= 2'(FLUSH_CYCLES - 1);
            end else if ((state == FLUSH) && (flush_cnt != 2'd0)) begin
                flush_cnt <= flush_cnt - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            base_addr <= req_addr;
            wdata_q   <= req_wdata;
        end
        if (capture) begin
            rbuf <= cap_bytes;
        end
    end

endmodule

// File: tb/tb_dcache_mem_client.sv
// Directed testbench for dcache_mem_client. A small controller model grants
// one cycle after each request, returns read bytes one cycle after the grant
// and logs writes. Each test drives a request and records every cycle's
// outputs relative to the accept cycle, then checks against hand-computed
// values.
module tb_dcache_mem_client;

    localparam int ADDR_W = 18;
    localparam int XLEN   = 32;
    localparam int NT     = 16;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              flush;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              mc_rw_en;
    logic              mc_write_mode;
    logic [ADDR_W-1:0] mc_addr;
    logic [7:0]        mc_data;
    logic              mc_out_en;
    logic [7:0]        mc_din;

    dcache_mem_client #(
        .ADDR_W (ADDR_W),
        .XLEN   (XLEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_signed    (req_signed),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .flush         (flush),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .mc_rw_en      (mc_rw_en),
        .mc_write_mode (mc_write_mode),
        .mc_addr       (mc_addr),
        .mc_data       (mc_data),
        .mc_out_en     (mc_out_en),
        .mc_din        (mc_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller model
    logic [7:0]  mem [0:(1<<ADDR_W)-1];
    logic [25:0] wlog [$];

    initial begin
        mc_out_en = 1'b0;
        mc_din    = 8'h00;
    end

    always @(posedge clk) begin
        mc_out_en <= mc_rw_en;
        if (mc_out_en && !mc_write_mode) begin
            mc_din <= mem[mc_addr];
        end
        if (mc_out_en && mc_write_mode) begin
            mem[mc_addr] <= mc_data;
            wlog.push_back({mc_addr, mc_data});
        end
    end

    // Per-cycle trace, indexed by cycle relative to the accept cycle
    logic              t_rw    [NT];
    logic              t_wm    [NT];
    logic              t_oe    [NT];
    logic              t_ready [NT];
    logic              t_rv    [NT];
    logic [ADDR_W-1:0] t_addr  [NT];
    logic [7:0]        t_data  [NT];
    logic [XLEN-1:0]   t_rdata [NT];

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] wd);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic step(input int c);
        @(negedge clk);
        t_rw[c]    = mc_rw_en;
        t_wm[c]    = mc_write_mode;
        t_oe[c]    = mc_out_en;
        t_ready[c] = req_ready;
        t_rv[c]    = resp_valid;
        t_addr[c]  = mc_addr;
        t_data[c]  = mc_data;
        t_rdata[c] = resp_rdata;
        @(posedge clk);
        #1;
    endtask

    // Second request launched at cycle nx_at (disabled when negative)
    int                nx_at;
    logic              nx_w;
    logic [1:0]        nx_sz;
    logic              nx_sg;
    logic [ADDR_W-1:0] nx_a;
    logic [XLEN-1:0]   nx_wd;

    task automatic run(input int n, input int flush_at, input int rst_at);
        for (int c = 0; c < n; c++) begin
            if (c == nx_at) issue(nx_w, nx_sz, nx_sg, nx_a, nx_wd);
            flush = (c == flush_at);
            rst   = (c == rst_at);
            step(c);
            if (c == 0 || c == nx_at) req_valid = 1'b0;
        end
        flush = 1'b0;
        rst   = 1'b0;
        nx_at = -1;
    endtask

    function automatic int count_rv(input int n);
        int s;
        s = 0;
        for (int c = 0; c < n; c++) if (t_rv[c]) s++;
        return s;
    endfunction

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        nx_at      = -1;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        flush      = 1'b0;
        mem[18'h00100] = 8'h78;
        mem[18'h00101] = 8'h56;
        mem[18'h00102] = 8'h34;
        mem[18'h00103] = 8'h12;
        mem[18'h3FFFF] = 8'h80;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_ready", 64'(req_ready), 64'd1);
        check("rst_resp", 64'({resp_valid, resp_rdata}), 64'd0);
        check("rst_mc", 64'({mc_rw_en, mc_write_mode, mc_addr, mc_data}), 64'd0);
        @(posedge clk);
        #1;

        // LW at 0x100
        issue(1'b0, 2'd2, 1'b0, 18'h00100, 32'h0);
        run(9, -1, -1);
        check("lw_rw1", 64'(t_rw[1]), 64'd1);
        for (int c = 2; c <= 5; c++) begin
            check($sformatf("lw_grant%0d", c), 64'(t_oe[c]), 64'd1);
            check($sformatf("lw_addr%0d", c), 64'(t_addr[c]), 64'(18'h00100 + c - 2));
            check($sformatf("lw_wm%0d", c), 64'(t_wm[c]), 64'd0);
        end
        check("lw_rw_drop", 64'(t_rw[5]), 64'd0);
        check("lw_no_grant6", 64'(t_oe[6]), 64'd0);
        check("lw_rv7", 64'(t_rv[7]), 64'd1);
        check("lw_rdata", 64'(t_rdata[7]), 64'h12345678);
        check("lw_rv_count", 64'(count_rv(9)), 64'd1);
        check("lw_ready7", 64'(t_ready[7]), 64'd1);

        // LB signed / unsigned at 0x3FFFF
        issue(1'b0, 2'd0, 1'b1, 18'h3FFFF, 32'h0);
        run(6, -1, -1);
        check("lbs_addr", 64'(t_addr[2]), 64'h3FFFF);
        check("lbs_rv4", 64'(t_rv[4]), 64'd1);
        check("lbs_rdata", 64'(t_rdata[4]), 64'hFFFFFF80);
        issue(1'b0, 2'd0, 1'b0, 18'h3FFFF, 32'h0);
        run(6, -1, -1);
        check("lbu_rv4", 64'(t_rv[4]), 64'd1);
        check("lbu_rdata", 64'(t_rdata[4]), 64'h00000080);

        // SH 0xBEEF at 0x3FFFF, second byte wraps to 0
        wlog.delete();
        issue(1'b1, 2'd1, 1'b0, 18'h3FFFF, 32'h0000BEEF);
        run(7, -1, -1);
        check("sh_wm2", 64'(t_wm[2]), 64'd1);
        check("sh_wm3", 64'(t_wm[3]), 64'd1);
        check("sh_wm4", 64'(t_wm[4]), 64'd0);
        check("sh_b0", 64'({t_addr[2], t_data[2]}), 64'({18'h3FFFF, 8'hEF}));
        check("sh_b1", 64'({t_addr[3], t_data[3]}), 64'({18'h00000, 8'hBE}));
        check("sh_rv4", 64'(t_rv[4]), 64'd1);
        check("sh_rdata", 64'(t_rdata[4]), 64'd0);
        check("sh_nwrites", 64'(wlog.size()), 64'd2);
        check("sh_mem", 64'({mem[18'h3FFFF], mem[18'h00000]}), 64'hEFBE);

        // LH signed at 0x3FFFF wraps and reads 0xBEEF
        issue(1'b0, 2'd1, 1'b1, 18'h3FFFF, 32'h0);
        run(7, -1, -1);
        check("lhs_addr3", 64'(t_addr[3]), 64'd0);
        check("lhs_rv5", 64'(t_rv[5]), 64'd1);
        check("lhs_rdata", 64'(t_rdata[5]), 64'hFFFFBEEF);

        // LW flushed in cycle 3, then LB at 0x100
        issue(1'b0, 2'd2, 1'b0, 18'h00100, 32'h0);
        run(9, 3, -1);
        check("fl_rw2", 64'(t_rw[2]), 64'd1);
        check("fl_rw3", 64'(t_rw[3]), 64'd0);
        check("fl_ready4", 64'(t_ready[4]), 64'd0);
        check("fl_ready5", 64'(t_ready[5]), 64'd0);
        check("fl_ready6", 64'(t_ready[6]), 64'd1);
        check("fl_no_resp", 64'(count_rv(9)), 64'd0);
        issue(1'b0, 2'd0, 1'b0, 18'h00100, 32'h0);
        run(6, -1, -1);
        check("fl_lb_rv4", 64'(t_rv[4]), 64'd1);
        check("fl_lb_rdata", 64'(t_rdata[4]), 64'h00000078);

        // Reset in cycle 3 of SW, then a fresh SB
        wlog.delete();
        issue(1'b1, 2'd2, 1'b0, 18'h00300, 32'hDEADBEEF);
        run(8, -1, 3);
        for (int c = 4; c < 8; c++) begin
            check($sformatf("rst_mid%0d", c),
                  64'({t_rw[c], t_wm[c], t_addr[c], t_data[c], t_rv[c], t_ready[c]}), 64'd1);
            check($sformatf("rst_mid_rdata%0d", c), 64'(t_rdata[c]), 64'd0);
        end
        check("rst_mid_nwrites", 64'(wlog.size()), 64'd2);
        issue(1'b1, 2'd0, 1'b0, 18'h00301, 32'h00000011);
        run(5, -1, -1);
        check("rst_sb_rv3", 64'(t_rv[3]), 64'd1);
        check("rst_sb_mem", 64'(mem[18'h00301]), 64'h11);

        // SB 0xA5 at 0x200, back-to-back LB unsigned at 0x200
        nx_at = 3;
        nx_w  = 1'b0;
        nx_sz = 2'd0;
        nx_sg = 1'b0;
        nx_a  = 18'h00200;
        nx_wd = 32'h0;
        issue(1'b1, 2'd0, 1'b0, 18'h00200, 32'h000000A5);
        run(10, -1, -1);
        check("b2b_sb_rv3", 64'(t_rv[3]), 64'd1);
        check("b2b_ready3", 64'(t_ready[3]), 64'd1);
        check("b2b_rw4", 64'(t_rw[4]), 64'd1);
        check("b2b_lb_rv7", 64'(t_rv[7]), 64'd1);
        check("b2b_lb_rdata", 64'(t_rdata[7]), 64'h000000A5);
        check("b2b_rv_count", 64'(count_rv(10)), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dcache_mem_client.md
# dcache_mem_client

Client-side engine for the dcache port of the byte-wide memory controller. It accepts one load or store of 1, 2 or 4 bytes from the load/store unit and runs it on the controller's 8-bit request/grant interface. Loads are reassembled little-endian and zero- or sign-extended; stores are split into byte writes. It sits between the LSU/dcache and the memory controller's `dcache_*` ports.

## Interface
Parameters:
- `ADDR_W`, 18: byte address width; address arithmetic wraps modulo 2^ADDR_W.
- `XLEN`, 32: request and response data width.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- `req_signed`  in  1  loads only: sign-extend when 1, zero-extend when 0.
- `req_addr`  in  ADDR_W  base byte address; any alignment is allowed.
- `req_wdata`  in  XLEN  store data; byte i is `req_wdata[8i+7:8i]`.
- `flush`  in  1  cancels an in-flight load; ignored for stores.
- `resp_valid`  out  1  one-cycle pulse: load data ready, or store complete.
- `resp_rdata`  out  XLEN  extended load data; 0 for stores.
- `mc_rw_en`  out  1  to controller `dcache_rw_en`.
- `mc_write_mode`  out  1  to controller `dcache_write_mode`.
- `mc_addr`  out  ADDR_W  to controller `dcache_addr`.
- `mc_data`  out  8  to controller `dcache_data`.
- `mc_out_en`  in  1  controller grant; equals `mc_rw_en` delayed by one cycle.
- `mc_din`  in  8  read byte; valid in the cycle after the grant cycle that issued it.

## Operation
- N = 1, 2 or 4 bytes from `req_size`. On accept, latch addr, wdata, write, size and signed; clear `idx` and `rcv`; enter ISSUE.
- ISSUE:
  - `mc_addr = base + idx` (wraps), `mc_data = wdata byte idx`, `mc_write_mode = write`.
  - Every cycle with `mc_out_en = 1` issues one byte and increments `idx`.
  - `mc_rw_en = (state == ISSUE) && !(mc_out_en && idx == N-1)`. It drops combinationally in the last grant cycle, so there is no trailing grant and no duplicate write.
- After the last issue, a store goes to IDLE and pulses `resp_valid` (registered). A load goes to WAIT.
- Read capture: a register `rd_pend <= mc_out_en && !write && state == ISSUE`. When `rd_pend = 1`, store `mc_din` into byte lane `rcv` and increment `rcv`.
- WAIT: capture the last byte, then register `resp_rdata` and pulse `resp_valid`; go to IDLE.
- Extension: bits above 8N are filled with `req_signed ? bit(8N-1) : 0`. Word loads are returned unmodified.
- Flush:
  - Load in ISSUE or WAIT: drop `mc_rw_en` immediately, suppress the response, and enter FLUSH for 2 cycles with `req_ready = 0`.
  - Any `mc_out_en` or `mc_din` seen during FLUSH is ignored. A stray grant is harmless because `mc_write_mode = 0`.
  - FLUSH returns to IDLE. Flush in IDLE, or during a store, has no effect.
- States: IDLE, ISSUE, WAIT, FLUSH.
- Reset: state = IDLE, `resp_valid = 0`, `resp_rdata = 0`, `idx = rcv = 0`, `rd_pend = 0`. This also applies mid-operation. A partially issued store is abandoned.
- Outside ISSUE: `mc_rw_en = 0`, `mc_write_mode = 0`, `mc_addr = 0`, `mc_data = 0`. `req_ready = 0` outside IDLE.

## Timing
- Accept in cycle 0. `mc_rw_en` is high from cycle 1, and grants occur in cycles 2 .. N+1.
- Read byte i arrives in cycle i+3.
- Load: `resp_valid` in cycle N+3 (LB = 4, LH = 5, LW = 7).
- Store: `resp_valid` in cycle N+2 (SB = 3, SH = 4, SW = 6).
- `req_ready` is high in the `resp_valid` cycle, so back-to-back requests are allowed. The next request's `mc_rw_en` rises the cycle after its accept.
- The controller gives dcache priority, so grants are contiguous once started. The block still tolerates gaps in `mc_out_en`: it issues only on grant.
- Simultaneous `flush` and final capture in WAIT: flush wins, and there is no `resp_valid`.

## Structure
- Shared package `mem_pkg`:
  - size encodings `MEM_B` = 0, `MEM_H` = 1, `MEM_W` = 2;
  - state enum `{IDLE, ISSUE, WAIT, FLUSH}`;
  - `FLUSH_CYCLES` = 2.
- Sub-module `load_extend`: combinational; inputs are the 4 captured bytes, size and signed; output is XLEN. Reused by the icache fetch path.

## Test plan
- LW at 0x00100, memory {0x78, 0x56, 0x34, 0x12} -> grants in cycles 2–5 with `mc_addr` 0x100–0x103 and `mc_write_mode = 0`; `resp_valid` in cycle 7 with `resp_rdata` = 0x12345678.
- LB signed at 0x3FFFF, byte 0x80 -> 0xFFFFFF80 in cycle 4. Same access unsigned -> 0x00000080.
- SH 0xBEEF at 0x3FFFF -> writes 0xEF to 0x3FFFF and 0xBE to 0x00000 (wrap); `mc_write_mode = 1` only in cycles 2–3; `resp_valid` in cycle 4; no third write.
- LW then flush in cycle 3 -> `mc_rw_en` low in cycle 3; no `resp_valid`; `req_ready` low in cycles 4–5. A following LB at 0x00100 returns 0x00000078.
- `rst` in cycle 3 of an SW -> from cycle 4 every output is 0 and `req_ready = 1`; a new SB completes normally.
- SB 0xA5 at 0x00200 immediately followed by LB unsigned at 0x00200 -> store `resp_valid` in cycle 3, new accept in cycle 3, load returns 0x000000A5 in cycle 7.
